// File: rtl/demux4_pkg.sv
// demux4_pkg: shared types and constants for the demux4_buf block.
//   slot_state_t : state of a one-entry channel slot (EMPTY / FULL)
//   NCH          : number of output channels
//   CNT_W        : width of the optional per-channel transfer counters
//   sat_inc      : saturating increment used by those counters
package demux4_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux4_slot.sv
// demux4_slot: one-entry buffer slot for a single demux channel.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : accept data this cycle (caller guarantees slot is free or draining)
//   data [N]   : word to store on load
//   drain      : consumer accepts the held word this cycle
//   valid      : slot holds an undelivered word
//   q [N]      : held word; keeps the last loaded value when empty (0 after reset)
module demux4_slot
    import demux4_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] data,
    input  logic         drain,
    output logic         valid,
    output logic [N-1:0] q
);

    slot_state_t state, state_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            q     <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                q <= data;
            end
        end
    end

    // A load while draining keeps the slot FULL with the new word.
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (load) state_nx = FULL;
            FULL:  if (load) state_nx = FULL;
                   else if (drain) state_nx = EMPTY;
        endcase
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 demultiplexer with a one-entry buffer per output channel.
// Optional macro: DEMUX4_BUF_CNT_EN adds cnt0..cnt3, saturating counts of
// input transfers per channel.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   d [N], s [2]   : upstream word and destination channel
//   in_valid       : upstream offers d/s
//   in_ready       : selected channel can take the word this cycle
//   y0..y3 [N]     : registered channel data
//   y_valid [4]    : channel i holds an undelivered word
//   y_ready [4]    : channel-i consumer accepts this cycle
//   cnt0..cnt3 [8] : (DEMUX4_BUF_CNT_EN only) input transfers per channel
module demux4_buf
    import demux4_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     d,
    input  logic [1:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     y0,
    output logic [N-1:0]     y1,
    output logic [N-1:0]     y2,
    output logic [N-1:0]     y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready
`ifdef DEMUX4_BUF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
`endif
);

    logic             xfer;
    logic [NCH-1:0]   load;
    logic [N-1:0]     q [NCH];

    // Reset forces ready high; the slots' own reset discards the transfer.
    assign in_ready = reset | ~y_valid[s] | y_ready[s];
    assign xfer     = in_valid & in_ready;
    assign load     = xfer ? (NCH'(1) << s) : '0;

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        demux4_slot #(.N(N)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[g]),
            .data  (d),
            .drain (y_ready[g]),
            .valid (y_valid[g]),
            .q     (q[g])
        );
    end

    assign y0 = q[0];
    assign y1 = q[1];
    assign y2 = q[2];
    assign y3 = q[3];

`ifdef DEMUX4_BUF_CNT_EN
    logic [CNT_W-1:0] cnt [NCH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];
`endif

endmodule

// File: doc/demux4_buf.md
DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 Parameter N, default 16, SHALL set the data width of the input and of every output channel.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 d  input  N  SHALL carry the upstream data word.
REQ-005 s  input  2  SHALL select the destination channel, 0..3.
REQ-006 in_valid  input  1  SHALL indicate that d/s hold a word offered by upstream.
REQ-007 in_ready  output  1  SHALL indicate that the selected channel can accept the word this cycle.
REQ-008 y0, y1, y2, y3  output  N each  SHALL be the registered channel data.
REQ-009 y_valid  output  4  SHALL set bit i when channel i holds an undelivered word.
REQ-010 y_ready  input  4  SHALL set bit i when the channel-i consumer accepts the word this cycle.

Function
REQ-011 Each channel SHALL be a one-entry slot with states EMPTY and FULL; y_valid[i] SHALL be 1 exactly when slot i is FULL.
REQ-012 in_ready SHALL be combinational and equal (slot s EMPTY) OR y_ready[s]; it SHALL NOT depend on in_valid.
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both high; d SHALL be written to slot s, and y_valid[s] SHALL be high from the next edge, giving 1-cycle latency.
REQ-014 An output transfer on channel i SHALL occur when y_valid[i] and y_ready[i] are both high.
REQ-015 Slot transitions: EMPTY->FULL on an input transfer; FULL->EMPTY on an output transfer without an input transfer; FULL->FULL with new data on a simultaneous input and output transfer to the same slot.
REQ-016 While a slot is FULL and not drained, its y SHALL hold stable.
REQ-017 When a slot is EMPTY, its y SHALL retain the last loaded value, or 0 if none has been loaded since reset.
REQ-018 An input transfer SHALL modify only slot s; other slots SHALL be unaffected and SHALL drain independently in the same cycle.
REQ-019 s and d MAY change in any cycle, including while in_valid is high and in_ready is low; the block SHALL evaluate in_ready against the current s.
REQ-020 y_ready[i] while slot i is EMPTY SHALL have no effect.

Reset
REQ-021 Reset SHALL set all slots to EMPTY: y_valid = 4'b0000, and y0..y3 = 0.
REQ-022 in_ready SHALL read 1 during and immediately after reset.
REQ-023 Reset asserted mid-operation SHALL discard all held words and override any simultaneous input or output transfer.

Configuration
REQ-024 Macro DEMUX4_BUF_CNT_EN, when defined, SHALL add four output ports cnt0..cnt3 (8 bits each), each counting input transfers to its channel.
REQ-025 With DEMUX4_BUF_CNT_EN defined, each counter SHALL reset to 0 and saturate at 255.
REQ-026 Without DEMUX4_BUF_CNT_EN, the cnt ports and counter logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-027 Package demux4_pkg SHALL hold: the slot-state enum (EMPTY, FULL), constant NCH = 4, and constant CNT_W = 8.
REQ-028 One sub-module, demux4_slot (parameter N; ports load, data, drain, valid, q), SHALL implement a single slot and SHALL be instantiated four times.

Verification
REQ-029 Reset, then in_valid=1, s=2, d=16'hBEEF for 1 cycle -> next cycle y_valid=4'b0100 and y2=16'hBEEF; the other y outputs are 0.
REQ-030 Slot 1 FULL, y_ready[1]=0, in_valid=1, s=1 -> in_ready=0; y1 holds; then with s=3 -> in_ready=1 and slot 3 loads.
REQ-031 Slot 0 FULL holding 16'h0001, y_ready[0]=1, in_valid=1, s=0, d=16'h0002 -> in_ready=1; next cycle y_valid[0]=1 and y0=16'h0002 (one-cycle swap).
REQ-032 Back-to-back words 16'h0010..16'h0013 to s=0..3, then y_ready=4'b1111 -> all four delivered in one cycle; y_valid returns to 0.
REQ-033 Reset asserted while y_valid=4'b1111 and an input transfer is pending -> next cycle y_valid=0, y0..y3=0, in_ready=1.
REQ-034 With DEMUX4_BUF_CNT_EN defined, 300 transfers to s=1 -> cnt1=255 and cnt0=cnt2=cnt3=0.
